// File: rtl/power_cu_pkg.sv
// Shared definitions for the power control unit.
// Holds the FSM state encoding (also exported on pcu_state for debug),
// default sizing constants, and the index-width helper used to size the
// register index and the ack-wait counter.
package power_cu_pkg;

  localparam int N_REGS_DFLT      = 53;
  localparam int WIDTH_DFLT       = 32;
  localparam int ACK_TIMEOUT_DFLT = 16;

  // Width needed to index n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_w(N_REGS_DFLT);

  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    STBY    = 3'd1,
    DRAIN   = 3'd2,
    BK_SCAN = 3'd3,
    BK_REQ  = 3'd4,
    OFF     = 3'd5,
    RS_SCAN = 3'd6,
    RS_WR   = 3'd7
  } pcu_state_t;

endpackage

// File: rtl/pcu_shadow_store.sv
// Non-volatile shadow copy of the core register file.
// Ports:
//   Clk, Rst           clock; Rst clears only the valid vector
//   wr_en/wr_idx/wr_data  single synchronous write port, marks entry valid
//   rd_idx             combinational read address
//   rd_data, rd_valid  stored value and its valid flag at rd_idx
module pcu_shadow_store
  import power_cu_pkg::*;
#(
  parameter int N_REGS = N_REGS_DFLT,
  parameter int WIDTH  = WIDTH_DFLT,
  parameter int IW     = idx_w(N_REGS)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  logic [WIDTH-1:0]  mem [N_REGS];
  logic [N_REGS-1:0] valid;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Data survives reset; only the valid bits decide what gets replayed.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data  = mem[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/power_cu.sv
// Power control unit for the RISC-V core.
// Power-off: wait for DRAM idle, stall the core, copy every dirty core
// register into the shadow store via backup_ens/backup_acks/backup_Vouts,
// then raise pwr_gate. Power-on: replay every valid shadow entry through
// restore_ens/restore_Vins, then release the core.
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   stand_by        light-sleep request (stall only)
//   Pwr_off         level-sensitive power-off request
//   dram_ack        DRAM idle
//   dirty_vals      2 bits per register, non-zero = needs backup
//   backup_acks     per-register ack, data valid on backup_Vouts same cycle
//   backup_Vouts    register values, WIDTH bits per register
//   backup_ens      one-hot backup request
//   restore_ens     one-hot single-cycle restore strobe
//   restore_Vins    restore data, only the strobed slice non-zero
//   core_hold       stall the core
//   pwr_gate        power-domain off enable
//   bk_err          sticky backup-ack timeout flag
//   pcu_state       current FSM state
module power_cu
  import power_cu_pkg::*;
#(
  parameter int N_REGS      = N_REGS_DFLT,
  parameter int WIDTH       = WIDTH_DFLT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DFLT
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    stand_by,
  input  logic                    Pwr_off,
  input  logic                    dram_ack,
  input  logic [2*N_REGS-1:0]     dirty_vals,
  input  logic [N_REGS-1:0]       backup_acks,
  input  logic [N_REGS*WIDTH-1:0] backup_Vouts,
  output logic [N_REGS-1:0]       backup_ens,
  output logic [N_REGS-1:0]       restore_ens,
  output logic [N_REGS*WIDTH-1:0] restore_Vins,
  output logic                    core_hold,
  output logic                    pwr_gate,
  output logic                    bk_err,
  output logic [2:0]              pcu_state
);

  localparam int IW = idx_w(N_REGS);
  localparam int CW = idx_w(ACK_TIMEOUT);

  pcu_state_t       state, state_nx;
  logic [IW-1:0]    idx, idx_nx;
  logic [CW-1:0]    ack_cnt, ack_cnt_nx;
  logic             bk_err_nx;
  logic [N_REGS-1:0] dirty;
  logic [WIDTH-1:0] vout [N_REGS];
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             last, ack_hit, ack_expired;

  for (genvar i = 0; i < N_REGS; i++) begin : g_slice
    assign dirty[i] = |dirty_vals[2*i +: 2];
    assign vout[i]  = backup_Vouts[i*WIDTH +: WIDTH];
    assign restore_Vins[i*WIDTH +: WIDTH] =
      (state == RS_WR && idx == IW'(i)) ? rd_data : '0;
  end

  assign last        = (idx == IW'(N_REGS-1));
  // Only the ack bit of the register currently requested counts.
  assign ack_hit     = backup_acks[idx];
  assign ack_expired = (ack_cnt == CW'(ACK_TIMEOUT-1));

  pcu_shadow_store #(
    .N_REGS (N_REGS),
    .WIDTH  (WIDTH),
    .IW     (IW)
  ) u_shadow (
    .Clk      (Clk),
    .Rst      (Rst),
    .wr_en    (state == BK_REQ && ack_hit),
    .wr_idx   (idx),
    .wr_data  (vout[idx]),
    .rd_idx   (idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ACTIVE;
      idx     <= '0;
      ack_cnt <= '0;
      bk_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      ack_cnt <= ack_cnt_nx;
      bk_err  <= bk_err_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    ack_cnt_nx = ack_cnt;
    bk_err_nx  = bk_err;
    unique case (state)
      ACTIVE: begin
        if (Pwr_off)       state_nx = DRAIN;
        else if (stand_by) state_nx = STBY;
      end
      STBY: begin
        if (Pwr_off)        state_nx = DRAIN;
        else if (!stand_by) state_nx = ACTIVE;
      end
      DRAIN: begin
        if (dram_ack) begin
          state_nx = BK_SCAN;
          idx_nx   = '0;
        end
      end
      BK_SCAN: begin
        if (dirty[idx]) state_nx = BK_REQ;
        else if (last)  state_nx = OFF;
        else            idx_nx   = idx + 1'b1;
      end
      BK_REQ: begin
        if (ack_hit || ack_expired) begin
          ack_cnt_nx = '0;
          if (!ack_hit) bk_err_nx = 1'b1;
          if (last) begin
            state_nx = OFF;
          end else begin
            state_nx = BK_SCAN;
            idx_nx   = idx + 1'b1;
          end
        end else begin
          ack_cnt_nx = ack_cnt + 1'b1;
        end
      end
      OFF: begin
        if (!Pwr_off) begin
          state_nx = RS_SCAN;
          idx_nx   = '0;
        end
      end
      RS_SCAN: begin
        if (rd_valid)  state_nx = RS_WR;
        else if (last) state_nx = ACTIVE;
        else           idx_nx   = idx + 1'b1;
      end
      RS_WR: begin
        if (last) begin
          state_nx = ACTIVE;
        end else begin
          state_nx = RS_SCAN;
          idx_nx   = idx + 1'b1;
        end
      end
      default: state_nx = ACTIVE;
    endcase
  end

  // Outputs depend only on registered state, idx and the shadow store.
  assign backup_ens  = (state == BK_REQ) ? (N_REGS'(1) << idx) : '0;
  assign restore_ens = (state == RS_WR)  ? (N_REGS'(1) << idx) : '0;
  assign core_hold   = (state != ACTIVE);
  assign pwr_gate    = (state == OFF);
  assign pcu_state   = state;

endmodule

// File: tb/tb_power_cu.sv
// Randomized self-checking bench for power_cu with a transaction-level model.
module tb_power_cu;
  import power_cu_pkg::*;

  localparam int N  = 53;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           Clk = 1'b0;
  logic           Rst, stand_by, Pwr_off, dram_ack;
  logic [2*N-1:0] dirty_vals;
  logic [N-1:0]   backup_acks;
  logic [N*W-1:0] backup_Vouts;
  logic [N-1:0]   backup_ens, restore_ens;
  logic [N*W-1:0] restore_Vins;
  logic           core_hold, pwr_gate, bk_err;
  logic [2:0]     pcu_state;

  power_cu #(.N_REGS(N), .WIDTH(W), .ACK_TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst), .stand_by(stand_by), .Pwr_off(Pwr_off),
    .dram_ack(dram_ack), .dirty_vals(dirty_vals), .backup_acks(backup_acks),
    .backup_Vouts(backup_Vouts), .backup_ens(backup_ens),
    .restore_ens(restore_ens), .restore_Vins(restore_Vins),
    .core_hold(core_hold), .pwr_gate(pwr_gate), .bk_err(bk_err),
    .pcu_state(pcu_state)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the shadow store should hold, derived from the
  // registers the bench chose to mark dirty and acknowledge.
  bit             sv_m [N];
  logic [W-1:0]   sd_m [N];
  bit             err_m;
  bit             dirty_m [N];
  int             lat [N];      // ack delay in cycles, -1 = never ack
  bit             use_fix;
  logic [W-1:0]   fixv [N];
  bit             from_drain;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic clear_dirty();
    dirty_vals = '0;
    for (int i = 0; i < N; i++) begin dirty_m[i] = 1'b0; lat[i] = 0; end
  endtask

  task automatic mark_dirty(input int i, input logic [1:0] code, input int l);
    dirty_vals[2*i +: 2] = code;
    dirty_m[i] = 1'b1;
    lat[i] = l;
  endtask

  task automatic rand_dirty(input int pct);
    clear_dirty();
    for (int i = 0; i < N; i++)
      if ($urandom_range(0, 99) < pct)
        mark_dirty(i, 2'($urandom_range(1, 3)),
                   ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3)));
  endtask

  task automatic drive_noise();
    for (int i = 0; i < N; i++) backup_Vouts[i*W +: W] = $urandom;
    backup_acks = N'({$urandom, $urandom}) & N'({$urandom, $urandom}) & N'({$urandom, $urandom});
  endtask

  // One full power-off / power-on cycle, starting at a negedge.
  task automatic power_cycle(input int dly, input int sb_mode, input bit drop_early, input bit late_on);
    int edges, exp_lat, dd, held, cur, prev, nv, k, ix;
    int bk_seen[$], bk_exp[$], rs_seen[$], rs_exp[$];
    bit ok_hold, ok_oh, ok_drain, ok_gate, ok_single, ok_held, ok_vz, done;
    logic [N*W-1:0] exp_vins;
    logic [N-1:0]   prev_rs;
    ok_hold = 1; ok_oh = 1; ok_drain = 1; ok_gate = 1; ok_single = 1; ok_held = 1; ok_vz = 1;
    exp_lat = (from_drain ? N + 1 : N + 2) + dly;
    for (int i = 0; i < N; i++)
      if (dirty_m[i]) begin
        bk_exp.push_back(i);
        exp_lat += (lat[i] < 0) ? TO : lat[i] + 1;
      end
    if (!from_drain && sb_mode == 1) begin
      stand_by = 1'b1;
      repeat (2) begin
        @(negedge Clk);
        check("stby_state", 64'(pcu_state), 64'(STBY));
        check("stby_outs", {core_hold, pwr_gate}, 2'b10);
      end
    end
    if (!from_drain && sb_mode == 2) stand_by = 1'b1;
    Pwr_off  = 1'b1;
    dram_ack = (dly == 0);
    dd = from_drain ? 1 : 0;
    edges = 0; held = 0; prev = -1; done = 0;
    while (!done) begin
      @(negedge Clk);
      edges++;
      if (edges == 1 && !from_drain) check("enter_drain", 64'(pcu_state), 64'(DRAIN));
      if (drop_early && edges == 5) Pwr_off = 1'b0;
      if (!core_hold) ok_hold = 0;
      if (pcu_state == DRAIN) begin
        dd++;
        if (backup_ens != '0) ok_drain = 0;
      end
      dram_ack = (dd > dly);
      drive_noise();
      if (backup_ens != '0) begin
        if (!$onehot(backup_ens)) ok_oh = 0;
        cur = oh_idx(backup_ens);
        if (prev < 0) begin bk_seen.push_back(cur); held = 0; end
        held++;
        if (lat[cur] >= 0 && held == lat[cur] + 1) begin
          backup_acks[cur] = 1'b1;
          if (use_fix) backup_Vouts[cur*W +: W] = fixv[cur];
          sd_m[cur] = backup_Vouts[cur*W +: W];
          sv_m[cur] = 1'b1;
        end else begin
          backup_acks[cur] = 1'b0;
        end
        prev = cur;
      end else begin
        if (prev >= 0) begin
          if (held != ((lat[prev] < 0) ? TO : lat[prev] + 1)) ok_held = 0;
          if (lat[prev] < 0) err_m = 1'b1;
        end
        prev = -1;
      end
      if (pwr_gate) done = 1;
      else if (edges > exp_lat + 40) begin
        check("off_bound", 64'(edges), 64'(exp_lat));
        done = 1;
      end
    end
    check("off_latency", 64'(edges), 64'(exp_lat));
    check("off_state", 64'(pcu_state), 64'(OFF));
    check("drain_cycles", 64'(dd), 64'(dly + 1));
    check("drain_no_bk", ok_drain, 1);
    check("hold_in_bk", ok_hold, 1);
    check("bk_onehot", ok_oh, 1);
    check("ack_hold_len", ok_held, 1);
    check("bk_count", 64'(bk_seen.size()), 64'(bk_exp.size()));
    for (int i = 0; i < bk_seen.size() && i < bk_exp.size(); i++)
      check("bk_order", 64'(bk_seen[i]), 64'(bk_exp[i]));
    check("bk_err_off", bk_err, err_m);

    stand_by = 1'b0;
    backup_acks = '0;
    if (!drop_early) begin
      k = $urandom_range(1, 3);
      repeat (k) begin
        @(negedge Clk);
        if (!pwr_gate || pcu_state != OFF) ok_gate = 0;
      end
      Pwr_off = 1'b0;
    end
    nv = 0;
    for (int i = 0; i < N; i++) if (sv_m[i]) begin rs_exp.push_back(i); nv++; end
    edges = 0; done = 0; prev_rs = '0;
    while (!done) begin
      @(negedge Clk);
      edges++;
      if (late_on && edges == 3) Pwr_off = 1'b1;
      if (pwr_gate) ok_gate = 0;
      if (restore_ens != '0) begin
        if (!$onehot(restore_ens)) ok_oh = 0;
        if ((restore_ens & prev_rs) != '0) ok_single = 0;
        ix = oh_idx(restore_ens);
        rs_seen.push_back(ix);
        exp_vins = '0;
        exp_vins[ix*W +: W] = sd_m[ix];
        check("rs_vins", restore_Vins === exp_vins, 1);
      end else if (restore_Vins != '0) begin
        ok_vz = 0;
      end
      prev_rs = restore_ens;
      if (!core_hold) done = 1;
      else if (edges > N + nv + 40) begin
        check("on_bound", 64'(edges), 64'(N + 1 + nv));
        done = 1;
      end
    end
    check("on_latency", 64'(edges), 64'(N + 1 + nv));
    check("on_state", 64'(pcu_state), 64'(ACTIVE));
    check("gate_window", ok_gate, 1);
    check("rs_single", ok_single, 1);
    check("rs_onehot", ok_oh, 1);
    check("rs_vins_idle", ok_vz, 1);
    check("rs_count", 64'(rs_seen.size()), 64'(rs_exp.size()));
    for (int i = 0; i < rs_seen.size() && i < rs_exp.size(); i++)
      check("rs_order", 64'(rs_seen[i]), 64'(rs_exp[i]));
    check("bk_err_on", bk_err, err_m);
    if (late_on) begin
      @(negedge Clk);
      check("late_redrain", 64'(pcu_state), 64'(DRAIN));
      from_drain = 1'b1;
    end else begin
      from_drain = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 64'(pcu_state), 64'(ACTIVE));
    check({tag, "_bk_ens"}, 64'(backup_ens), 0);
    check({tag, "_rs_ens"}, 64'(restore_ens), 0);
    check({tag, "_rs_vins"}, restore_Vins == '0, 1);
    check({tag, "_flags"}, {core_hold, pwr_gate, bk_err}, 0);
  endtask

  task automatic rst_mid_backup();
    int edges;
    clear_dirty();
    mark_dirty(10, 2'b10, -1);
    Pwr_off = 1'b1; dram_ack = 1'b1; edges = 0;
    while (!backup_ens[10] && edges < 200) begin
      @(negedge Clk); edges++;
      drive_noise(); backup_acks[10] = 1'b0;
    end
    check("reach_bkreq10", backup_ens[10], 1);
    repeat (3) begin @(negedge Clk); drive_noise(); backup_acks[10] = 1'b0; end
    check("bkreq10_state", 64'(pcu_state), 64'(BK_REQ));
    Rst = 1'b1; Pwr_off = 1'b0; backup_acks = '0;
    @(negedge Clk);
    check_all_zero("rst_mid");
    Rst = 1'b0;
    for (int i = 0; i < N; i++) sv_m[i] = 1'b0;
    err_m = 1'b0;
    clear_dirty();
    power_cycle(0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1; stand_by = 1'b0; Pwr_off = 1'b0; dram_ack = 1'b0;
    dirty_vals = '0; backup_acks = '0; backup_Vouts = '0;
    err_m = 1'b0; use_fix = 1'b0; from_drain = 1'b0;
    for (int i = 0; i < N; i++) begin sv_m[i] = 1'b0; sd_m[i] = '0; fixv[i] = '0; end
    clear_dirty();
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    Rst = 1'b0;

    clear_dirty();
    power_cycle(0, 0, 0, 0);

    clear_dirty();
    mark_dirty(0, 2'b01, 2); mark_dirty(7, 2'b11, 2); mark_dirty(52, 2'b01, 2);
    fixv[0] = 32'hDEADBEEF; fixv[7] = 32'h12345678; fixv[52] = 32'hFFFFFFFF;
    use_fix = 1'b1;
    power_cycle(0, 0, 0, 0);
    use_fix = 1'b0;

    clear_dirty();
    mark_dirty(3, 2'b01, -1);
    power_cycle(0, 0, 0, 0);
    check("bk_err_set", bk_err, 1);

    clear_dirty();
    power_cycle(10, 0, 0, 0);
    check("bk_err_sticky", bk_err, 1);

    rand_dirty(5); power_cycle(0, 1, 0, 0);
    rand_dirty(5); power_cycle(2, 2, 0, 0);
    rand_dirty(5); power_cycle(1, 0, 1, 1);
    rand_dirty(5); power_cycle(0, 0, 0, 0);

    rst_mid_backup();

    for (int r = 0; r < 10; r++) begin
      rand_dirty(8);
      power_cycle($urandom_range(0, 4), from_drain ? 0 : int'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
